rr_grant_fsm: RTL and testbench
===============================

Name: rr_grant_fsm

Overview:
- Parametrised successor to the single-channel request/grant/revoke FSM.
- Arbitrates N_CH requesters onto one shared resource using round-robin priority.
- Drives the full grant lifecycle IDLE -> GRANT -> REVOKE, with a programmable hold timeout that forces a revoke when other channels are waiting.
- Sits between the requesting agents and the shared resource controller.

Parameters:
- N_CH, 4: number of requesting channels; legal range 2..32.
- MAX_HOLD, 16: maximum grant-hold cycles before a forced revoke; 0 disables the timeout.
- IDX_W, $clog2(N_CH): width of the grant index (derived; do not override).
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1): width of the hold counter (derived).

Ports:
- i_ck  input  1  clock; all state updates on its rising edge.
- i_arst  input  1  reset; synchronous, active-high, sampled on the i_ck rising edge.
- i_req  input  N_CH  per-channel request level; the owner drops it to release the grant or to acknowledge a revoke.
- o_grant  output  N_CH  one-hot grant, registered; all zero when no channel owns the resource.
- o_grantValid  output  1  OR of o_grant, registered.
- o_grantIdx  output  IDX_W  index of the current owner; 0 when o_grantValid=0.
- o_revoke  output  1  the current owner must release; asserted only while o_grantValid=1.
- o_state  output  2  FSM state encoding: 0=IDLE, 1=GRANT, 2=REVOKE; 3 is illegal.

Behaviour:
- Reset (i_arst=1 at an edge):
  - state=IDLE; o_grant=0; o_grantValid=0; o_grantIdx=0; o_revoke=0.
  - Hold counter=0; last-owner pointer=N_CH-1, so channel 0 wins first.
  - Reset mid-grant drops the grant on the next edge with no revoke phase.
- IDLE:
  - If i_req != 0, select the first set bit searching from pointer+1 upward, wrapping modulo N_CH.
  - Next cycle: state=GRANT, o_grant=onehot(winner), o_grantIdx=winner, pointer=winner, counter=0.
  - Latency from request to grant is 1 cycle.
  - If i_req=0, remain in IDLE.
- GRANT:
  - If i_req[owner]=0: next state=IDLE and the grant clears on the next edge.
    - At least one IDLE cycle always separates consecutive grants.
  - Otherwise the counter increments, saturating at MAX_HOLD.
  - If MAX_HOLD!=0, the counter has reached MAX_HOLD-1, and any other i_req bit is set: next state=REVOKE with o_revoke=1.
    - The revoke therefore asserts on hold cycle MAX_HOLD+1 counted from the grant edge.
  - If no other channel is requesting, the owner keeps the grant indefinitely with the counter saturated.
    - A later competing request then triggers REVOKE on the following edge.
- REVOKE:
  - o_grant, o_grantIdx and o_revoke remain asserted until i_req[owner]=0.
  - On that edge: next state=IDLE, all outputs clear.
  - There is no timeout on the acknowledge.
- Simultaneous events:
  - Owner release in the same cycle as timeout expiry: release wins, so next state is IDLE with no o_revoke pulse.
  - New requests arriving in GRANT or REVOKE are ignored until the next IDLE arbitration.
- Illegal state 3 returns to IDLE on the next edge with all outputs cleared.
- Invariants:
  - o_grant is one-hot or zero.
  - o_revoke=1 implies o_state=2.
  - o_grantValid == |o_grant.

Test Plan:
- Reset, then i_req=4'b0001 held -> o_grant=0001 one cycle later, o_state=1; still 0001 after 100 cycles with no revoke, because no other channel is requesting.
- i_req=4'b1111 held, each owner dropping its request 3 cycles after grant and reasserting 2 cycles later -> grant order 0,1,2,3,0,... with one IDLE cycle between grants.
- MAX_HOLD=16; ch1 granted, then ch2 requests -> o_revoke=1 on cycle 17 after the grant edge; ch1 drops i_req 5 cycles later -> IDLE one cycle, then o_grant=0100.
- Owner drops i_req on the exact cycle the counter reaches MAX_HOLD-1 while ch3 is waiting -> o_revoke never asserts; next state is IDLE, then ch3 is granted.
- i_arst=1 while in REVOKE with o_grant=0010 -> all outputs 0 on the next edge; with i_req=1111 after reset, channel 0 is granted first.
- MAX_HOLD=0, N_CH=8, all requesting, owner never releases -> o_revoke is never asserted and the grant persists for 1000 cycles.

Source files
------------

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter for N_CH requesters sharing one resource. Each grant goes
// through IDLE -> GRANT -> REVOKE, with an optional hold timeout that forces a revoke.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no owner; arbitrate among pending requests each cycle
// GRANT  | one channel owns the resource; hold counter running
// REVOKE | owner asked to release; waiting for its request to drop
// BAD    | unreachable encoding; recovers to IDLE with outputs cleared

module rr_grant_fsm #(
    parameter int N_CH     = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic              i_ck,
    input  logic              i_arst,
    input  logic [N_CH-1:0]   i_req,
    output logic [N_CH-1:0]   o_grant,
    output logic              o_grantValid,
    output logic [IDX_W-1:0]  o_grantIdx,
    output logic              o_revoke,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_REVOKE = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_TOP  = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               revoke_q, revoke_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               any_req;
    logic               owner_req;
    logic               others_req;
    logic               hold_expired;
    logic               cnt_sat;
    logic [IDX_W-1:0]   win_idx;
    logic [N_CH-1:0]    win_onehot;

    // First requester strictly after the last owner, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_CH-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

    always_comb begin
        win_idx    = rr_pick(i_req, ptr_q);
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign any_req      = |i_req;
    assign owner_req    = |(i_req & grant_q);
    assign others_req   = |(i_req & ~grant_q);
    assign cnt_sat      = (cnt_q == HOLD_TOP);
    assign hold_expired = HOLD_EN && (cnt_q >= HOLD_LAST);

    always_ff @(posedge i_ck) begin
        if (i_arst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            revoke_q <= 1'b0;
            ptr_q    <= PTR_INIT;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            revoke_q <= revoke_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        revoke_d = revoke_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d  = ST_GRANT;
                    grant_d  = win_onehot;
                    valid_d  = 1'b1;
                    idx_d    = win_idx;
                    ptr_d    = win_idx;
                    revoke_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            ST_GRANT: begin
                // Release takes priority over a timeout expiring on the same edge.
                if (!owner_req) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    revoke_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    if (!cnt_sat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (hold_expired && others_req) begin
                        state_d  = ST_REVOKE;
                        revoke_d = 1'b1;
                    end
                end
            end

            ST_REVOKE: begin
                if (!owner_req) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    revoke_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                valid_d  = 1'b0;
                idx_d    = '0;
                revoke_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    assign o_grant      = grant_q;
    assign o_grantValid = valid_q;
    assign o_grantIdx   = idx_q;
    assign o_revoke     = revoke_q;
    assign o_state      = state_q;

    a_grant_onehot: assert property (@(posedge i_ck) disable iff (i_arst)
        $onehot0(grant_q));
    a_revoke_state: assert property (@(posedge i_ck) disable iff (i_arst)
        revoke_q |-> (state_q == ST_REVOKE));
    a_valid_or: assert property (@(posedge i_ck) disable iff (i_arst)
        valid_q == (|grant_q));

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Scoreboarded bench for rr_grant_fsm: two instances (4 ch / hold 16, 8 ch / no timeout)
// driven by directed and random request patterns and checked against a queue-based model.

module tb_rr_grant_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] req_a;
    logic [7:0] req_b;
    logic [3:0] grant_a;
    logic [7:0] grant_b;
    logic       valid_a, valid_b;
    logic [1:0] idx_a;
    logic [2:0] idx_b;
    logic       rev_a, rev_b;
    logic [1:0] state_a, state_b;

    rr_grant_fsm #(.N_CH(4), .MAX_HOLD(16)) dut_a (
        .i_ck(clk), .i_arst(rst_a), .i_req(req_a), .o_grant(grant_a),
        .o_grantValid(valid_a), .o_grantIdx(idx_a), .o_revoke(rev_a), .o_state(state_a)
    );

    rr_grant_fsm #(.N_CH(8), .MAX_HOLD(0)) dut_b (
        .i_ck(clk), .i_arst(rst_b), .i_req(req_b), .o_grant(grant_b),
        .o_grantValid(valid_b), .o_grantIdx(idx_b), .o_revoke(rev_b), .o_state(state_b)
    );

    typedef struct {
        logic [31:0] grant;
        int          idx;
        bit          rev;
        int          st;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_ch[2]   = '{4, 8};
    int max_h[2]  = '{16, 0};
    int m_owner[2] = '{-1, -1};
    int m_last[2]  = '{3, 7};
    int m_held[2]  = '{0, 0};
    bit m_rev[2]   = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: owner as an integer, elapsed grant cycles unbounded.
    task automatic model_step(input int d, input logic [31:0] req, input bit rst, output exp_t e);
        logic [31:0] others;
        int c;
        if (rst) begin
            m_owner[d] = -1;
            m_rev[d]   = 1'b0;
            m_held[d]  = 0;
            m_last[d]  = n_ch[d] - 1;
        end else if (m_owner[d] < 0) begin
            for (int k = 1; k <= n_ch[d]; k++) begin
                c = (m_last[d] + k) % n_ch[d];
                if (m_owner[d] < 0 && ((req >> c) & 32'd1) != 0) begin
                    m_owner[d] = c;
                    m_last[d]  = c;
                    m_held[d]  = 0;
                end
            end
        end else if (((req >> m_owner[d]) & 32'd1) == 0) begin
            m_owner[d] = -1;
            m_rev[d]   = 1'b0;
        end else if (!m_rev[d]) begin
            m_held[d]++;
            others = req & ~(32'd1 << m_owner[d]);
            if (n_ch[d] < 32) others = others & ((32'd1 << n_ch[d]) - 32'd1);
            if (max_h[d] > 0 && m_held[d] >= max_h[d] && others != 0) m_rev[d] = 1'b1;
        end
        e.grant = (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
        e.idx   = (m_owner[d] >= 0) ? m_owner[d] : 0;
        e.rev   = m_rev[d];
        e.st    = (m_owner[d] < 0) ? 0 : (m_rev[d] ? 2 : 1);
    endtask

    task automatic cycle();
        exp_t e;
        model_step(0, 32'(req_a), rst_a, e);
        q_a.push_back(e);
        model_step(1, 32'(req_b), rst_b, e);
        q_b.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_grant",  32'(grant_a), e.grant);
                check("a_valid",  32'(valid_a), 32'(e.grant != 0));
                check("a_idx",    32'(idx_a),   32'(e.idx));
                check("a_revoke", 32'(rev_a),   32'(e.rev));
                check("a_state",  32'(state_a), 32'(e.st));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_grant",  32'(grant_b), e.grant);
                check("b_valid",  32'(valid_b), 32'(e.grant != 0));
                check("b_idx",    32'(idx_b),   32'(e.idx));
                check("b_revoke", 32'(rev_b),   32'(e.rev));
                check("b_state",  32'(state_b), 32'(e.st));
            end
        end
    end

    initial begin
        int n;
        int age;
        int prev_own;
        int grants;
        int rev_seen;
        int off[4];
        bit prev_v;

        rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0;
        #2;
        cycle();
        cycle();

        // Lone requester keeps the grant with no competition.
        rst_a = 1'b0;
        req_a = 4'b0001;
        cycle();
        check("p1_first_grant", 32'(grant_a), 32'h1);
        check("p1_first_state", 32'(state_a), 32'd1);
        repeat (100) cycle();
        check("p1_hold_grant",  32'(grant_a), 32'h1);
        check("p1_hold_revoke", 32'(rev_a),   32'd0);

        // All requesting, owners release after 3 cycles: strict rotation.
        rst_a = 1'b1; cycle(); rst_a = 1'b0;
        off = '{0, 0, 0, 0};
        age = 0; prev_own = -1; grants = 0; prev_v = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (m_owner[0] >= 0) age = (m_owner[0] == prev_own) ? age + 1 : 1;
            else age = 0;
            prev_own = m_owner[0];
            if (m_owner[0] >= 0 && age == 3) off[m_owner[0]] = 2;
            req_a = '0;
            for (int ch = 0; ch < 4; ch++) begin
                if (off[ch] == 0) req_a = req_a | 4'(1 << ch);
                else off[ch]--;
            end
            cycle();
            if (valid_a && !prev_v) begin
                check("p2_rr_order", 32'(idx_a), 32'(grants % 4));
                grants++;
            end
            prev_v = valid_a;
        end
        check("p2_grant_count", 32'(grants >= 16), 32'd1);

        // Competing request: revoke on cycle 17 after the grant edge.
        rst_a = 1'b1; req_a = '0; cycle(); rst_a = 1'b0;
        req_a = 4'b0010;
        cycle();
        check("p3_grant", 32'(grant_a), 32'h2);
        req_a = 4'b0110;
        n = 1;
        while (!rev_a && n < 40) begin
            cycle();
            n++;
        end
        check("p3_revoke_cycle", 32'(n), 32'd17);
        repeat (5) cycle();
        check("p3_revoke_held", 32'(rev_a), 32'd1);
        req_a = 4'b0100;
        cycle();
        check("p3_idle_state", 32'(state_a), 32'd0);
        check("p3_idle_grant", 32'(grant_a), 32'h0);
        cycle();
        check("p3_next_grant", 32'(grant_a), 32'h4);

        // Release on the same edge the timeout would fire: no revoke.
        rst_a = 1'b1; req_a = '0; cycle(); rst_a = 1'b0;
        req_a = 4'b0001;
        cycle();
        check("p4_grant", 32'(grant_a), 32'h1);
        req_a = 4'b1001;
        repeat (15) cycle();
        check("p4_pre_revoke", 32'(rev_a),   32'd0);
        check("p4_pre_state",  32'(state_a), 32'd1);
        req_a = 4'b1000;
        cycle();
        check("p4_no_revoke", 32'(rev_a),   32'd0);
        check("p4_idle",      32'(state_a), 32'd0);
        cycle();
        check("p4_ch3_grant", 32'(grant_a), 32'h8);

        // Reset while revoking clears everything; channel 0 wins afterwards.
        rst_a = 1'b1; req_a = '0; cycle(); rst_a = 1'b0;
        req_a = 4'b0010;
        cycle();
        req_a = 4'b0110;
        n = 0;
        while (!rev_a && n < 40) begin
            cycle();
            n++;
        end
        check("p5_in_revoke", 32'({rev_a, grant_a}), 32'h12);
        rst_a = 1'b1; req_a = 4'b1111;
        cycle();
        check("p5_rst_grant",  32'(grant_a), 32'h0);
        check("p5_rst_valid",  32'(valid_a), 32'd0);
        check("p5_rst_idx",    32'(idx_a),   32'd0);
        check("p5_rst_revoke", 32'(rev_a),   32'd0);
        check("p5_rst_state",  32'(state_a), 32'd0);
        rst_a = 1'b0;
        cycle();
        check("p5_first_after_rst", 32'(grant_a), 32'h1);

        // Random traffic on both instances.
        rst_b = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst_a = ($urandom_range(0, 63) == 0);
            rst_b = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req_b = 8'($urandom);
            if (m_owner[0] >= 0 && $urandom_range(0, 5) == 0) req_a = req_a & ~4'(1 << m_owner[0]);
            if (m_owner[1] >= 0 && $urandom_range(0, 5) == 0) req_b = req_b & ~8'(1 << m_owner[1]);
            cycle();
        end

        // No timeout: owner keeps the grant despite everyone waiting.
        rst_a = 1'b0; req_a = '0;
        rst_b = 1'b1; req_b = '0; cycle(); rst_b = 1'b0;
        req_b = 8'hFF;
        rev_seen = 0;
        repeat (1000) begin
            cycle();
            if (rev_b) rev_seen++;
        end
        check("p7_no_revoke", 32'(rev_seen), 32'd0);
        check("p7_grant",     32'(grant_b),  32'h1);

        @(negedge clk);
        #1;
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
